// File: rtl/hazard_fwd_if.sv
// Bundle between the ID/EX pipeline control and the hazard/forwarding unit.
// master: pipeline side (drives ID fields, br_taken); slave: the unit (drives stall/flush/fwd/counters).
interface hazard_fwd_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_src1;
  logic [REG_ADDR_W-1:0] id_src2;
  logic                  id_src2_used;
  logic [REG_ADDR_W-1:0] id_dst;
  logic                  id_wb_en;
  logic                  id_mem_read;
  logic                  br_taken;
  logic                  stall;
  logic                  flush;
  logic [1:0]            fwd_sel_a;
  logic [1:0]            fwd_sel_b;
  logic                  id_bypass_a;
  logic                  id_bypass_b;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output id_valid, id_src1, id_src2, id_src2_used,
    output id_dst, id_wb_en, id_mem_read, br_taken,
    input  stall, flush, fwd_sel_a, fwd_sel_b,
    input  id_bypass_a, id_bypass_b, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_src1, id_src2, id_src2_used,
    input  id_dst, id_wb_en, id_mem_read, br_taken,
    output stall, flush, fwd_sel_a, fwd_sel_b,
    output id_bypass_a, id_bypass_b, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Hazard detection + EX forwarding control for a 5-stage pipeline.
// Ports: clk, rst (async, active-high), bus (hazard_fwd_if.slave: ID fields in; stall/flush/fwd/bypass/counters out).
module hazard_fwd_unit #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned FWD_EN     = 1,
  parameter int unsigned CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  hazard_fwd_if.slave bus
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t dst;
    logic wb_en;
    logic mem_read;
    reg_t src1;
    reg_t src2;
    logic src2_used;
  } ex_slot_t;

  typedef struct packed {
    logic valid;
    reg_t dst;
    logic wb_en;
  } wb_slot_t;

  localparam logic             FWD     = (FWD_EN != 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ex_slot_t         ex_q, ex_d;
  wb_slot_t         mem_q, mem_d;
  wb_slot_t         wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       haz_ex, haz_mem, haz_wb;
  logic       stall_raw, stall_c, flush_c;
  logic [1:0] fwd_a_c, fwd_b_c;
  logic       byp_a_c, byp_b_c;

  // A slot produces r only for a real, writing instruction; r0 never counts.
  function automatic logic writes(
    input logic v,
    input logic wb,
    input reg_t dst,
    input reg_t r
  );
    return v & wb & (dst == r) & (r != '0);
  endfunction

  always_comb begin
    haz_ex  = writes(ex_q.valid, ex_q.wb_en, ex_q.dst, bus.id_src1)
            | (bus.id_src2_used
               & writes(ex_q.valid, ex_q.wb_en, ex_q.dst, bus.id_src2));
    haz_mem = writes(mem_q.valid, mem_q.wb_en, mem_q.dst, bus.id_src1)
            | (bus.id_src2_used
               & writes(mem_q.valid, mem_q.wb_en, mem_q.dst, bus.id_src2));
    haz_wb  = writes(wb_q.valid, wb_q.wb_en, wb_q.dst, bus.id_src1)
            | (bus.id_src2_used
               & writes(wb_q.valid, wb_q.wb_en, wb_q.dst, bus.id_src2));

    if (FWD) begin
      stall_raw = haz_ex & ex_q.mem_read;
    end else begin
      stall_raw = haz_ex | haz_mem | haz_wb;
    end

    // Branch redirect wins over stall; everything is quiet under reset.
    flush_c = bus.br_taken & ~rst;
    stall_c = bus.id_valid & ~bus.br_taken & stall_raw & ~rst;

    fwd_a_c = 2'd0;
    fwd_b_c = 2'd0;
    byp_a_c = 1'b0;
    byp_b_c = 1'b0;
    if (FWD && !rst) begin
      // The MEM slot is the younger producer, so it wins over WB.
      if (writes(mem_q.valid, mem_q.wb_en, mem_q.dst, ex_q.src1)) begin
        fwd_a_c = 2'd1;
      end else if (writes(wb_q.valid, wb_q.wb_en, wb_q.dst, ex_q.src1)) begin
        fwd_a_c = 2'd2;
      end
      if (ex_q.src2_used) begin
        if (writes(mem_q.valid, mem_q.wb_en, mem_q.dst, ex_q.src2)) begin
          fwd_b_c = 2'd1;
        end else if (writes(wb_q.valid, wb_q.wb_en, wb_q.dst, ex_q.src2)) begin
          fwd_b_c = 2'd2;
        end
      end
      byp_a_c = writes(wb_q.valid, wb_q.wb_en, wb_q.dst, bus.id_src1);
      byp_b_c = bus.id_src2_used
              & writes(wb_q.valid, wb_q.wb_en, wb_q.dst, bus.id_src2);
    end

    wb_d  = mem_q;
    mem_d = '{valid: ex_q.valid, dst: ex_q.dst, wb_en: ex_q.wb_en};
    ex_d  = '0;
    if (bus.id_valid && !stall_c && !flush_c) begin
      ex_d.valid     = 1'b1;
      ex_d.dst       = bus.id_dst;
      ex_d.wb_en     = bus.id_wb_en;
      ex_d.mem_read  = bus.id_mem_read;
      ex_d.src1      = bus.id_src1;
      ex_d.src2      = bus.id_src2;
      ex_d.src2_used = bus.id_src2_used;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall_c && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush_c && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.flush       = flush_c;
  assign bus.fwd_sel_a   = fwd_a_c;
  assign bus.fwd_sel_b   = fwd_b_c;
  assign bus.id_bypass_a = byp_a_c;
  assign bus.id_bypass_b = byp_b_c;
  assign bus.stall_cnt   = stall_cnt_q;
  assign bus.flush_cnt   = flush_cnt_q;

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps an internal shadow pipeline holding per-stage destination, source and load tags for the EX, MEM and WB slots.
- From that state it drives stall, flush and EX-operand forwarding selects, so back-to-back dependent instructions run correctly.
- It also keeps saturating performance counters for stall cycles and flushes.

Parameters:
- REG_ADDR_W, 5: register address width; register 0 is hard-wired zero.
- FWD_EN, 1: 1 = forwarding mode, which stalls only on load-use. 0 = interlock-only mode, which stalls on any in-flight writer.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_src1  in  REG_ADDR_W  ID source register 1
- id_src2  in  REG_ADDR_W  ID source register 2
- id_src2_used  in  1  src2 is read; 0 for immediate forms
- id_dst  in  REG_ADDR_W  ID destination register
- id_wb_en  in  1  ID instruction writes back
- id_mem_read  in  1  ID instruction is a load
- br_taken  in  1  branch resolved taken in EX this cycle
- stall  out  1  freeze PC and IF/ID; insert a bubble into ID/EX
- flush  out  1  clear IF/ID and ID/EX
- fwd_sel_a  out  2  EX operand A source: 0 = ID/EX value, 1 = EX/MEM ALU result, 2 = MEM/WB write value
- fwd_sel_b  out  2  EX operand B source; same encoding as fwd_sel_a
- id_bypass_a  out  1  ID src1 equals the WB-slot destination; select the WB write value
- id_bypass_b  out  1  same check for ID src2
- stall_cnt  out  CNT_W  count of cycles with stall=1
- flush_cnt  out  CNT_W  count of cycles with flush=1

Behaviour:
- Shadow pipeline registers:
  - EX slot: valid, dst, wb_en, mem_read, src1, src2, src2_used.
  - MEM slot and WB slot: valid, dst, wb_en.
- A slot "writes R" when it is valid, has wb_en=1, dst==R and R!=0. Register 0 never causes a stall, forward or bypass.
- Hazard terms (combinational from the ID inputs and slot state; each src2 term requires id_src2_used):
  - haz_ex: the EX slot writes id_src1 or id_src2.
  - haz_mem: the MEM slot writes id_src1 or id_src2.
  - haz_wb: the WB slot writes id_src1 or id_src2.
- stall (combinational, qualified by id_valid and !br_taken):
  - FWD_EN=1: stall = haz_ex with EX-slot mem_read=1 (load-use).
  - FWD_EN=0: stall = haz_ex | haz_mem | haz_wb.
- flush = br_taken. It is combinational and takes priority: when br_taken=1, stall=0.
- Shadow pipeline update on each rising clk:
  - WB slot <= MEM slot; MEM slot <= EX slot.
  - EX slot <= ID fields when id_valid & !stall & !flush; otherwise EX slot <= bubble (valid=0).
- Forwarding (combinational from the EX-slot sources):
  - fwd_sel_a = 1 if the MEM slot writes EX src1; else 2 if the WB slot writes EX src1; else 0.
  - The MEM slot (most recent producer) wins over the WB slot.
  - fwd_sel_b uses the same rule on EX src2, gated by src2_used.
  - FWD_EN=0: fwd_sel_a = fwd_sel_b = 0 always.
- id_bypass_a/b = the WB slot writes id_src1 / id_src2 (src2 term gated by id_src2_used).
  - Active only when FWD_EN=1; tied 0 when FWD_EN=0.
- Latencies for a dependent pair issued back-to-back:
  - FWD_EN=1, ALU producer: 0 stall cycles.
  - FWD_EN=1, load producer: 1 stall cycle.
  - FWD_EN=0: 3 stall cycles.
- Counters: increment by 1 on a clock edge when stall (resp. flush) is 1, and saturate at all-ones.
- Reset: asynchronous, active-high.
  - Clears all slot valids, all counters and all stored fields to 0.
  - All outputs are 0 while rst=1.
  - Reset asserted mid-stall drops the stall immediately and discards every in-flight slot.

Test Plan:
- FWD_EN=1, add r1 then add r2,r1,r1 back-to-back -> stall never asserts; fwd_sel_a=1 and fwd_sel_b=1 in the cycle the consumer is in EX; stall_cnt stays 0.
- FWD_EN=1, lw r3 then add r4,r3,r0 -> stall=1 for exactly 1 cycle with the EX slot a bubble; in the next cycle the consumer is in EX with fwd_sel_a=2; stall_cnt=1.
- FWD_EN=0, add r1 then sub r5,r1,r2 -> stall=1 for 3 consecutive cycles; fwd_sel stays 0; stall_cnt=3.
- Producer with dst=r0 followed by a consumer reading r0 (both modes) -> no stall, fwd_sel=0, id_bypass=0.
- Load-use stall and br_taken=1 in the same cycle -> flush=1 and stall=0; the EX slot becomes a bubble next cycle; flush_cnt=1, stall_cnt unchanged.
- Counter saturation and reset:
  - With CNT_W=2, hold a permanent stall for 5 cycles -> stall_cnt=3.
  - Then assert rst mid-stall -> all outputs 0 immediately; after release, no stall until a new hazard is issued.
